// File: rtl/sha_pkg.sv
// Shared constants and state type for the SHA message front end.
// Holds the single-block byte limit, counter width and assembler states.
package sha_pkg;

    localparam int MAX_BYTES = 55;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        DRAIN   = 2'd2,
        WAIT    = 2'd3
    } asm_state_t;

endpackage

// File: rtl/sha_msg_assembler.sv
// Packs a byte stream into one single-block message word for the SHA-256 top.
// Ports: clk, rst_n (async low); s_data/s_valid/s_last/s_ready byte stream in;
//   hash_done from the hash core; msg_valid/byte_valid/msg_word message out;
//   ovf pulses when a message was truncated to MAX_BYTES.
module sha_msg_assembler #(
    parameter int MAX_BYTES = sha_pkg::MAX_BYTES,
    parameter int CNT_W     = sha_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic                   hash_done,
    output logic                   msg_valid,
    output logic [CNT_W-1:0]       byte_valid,
    output logic [8*MAX_BYTES-1:0] msg_word,
    output logic                   ovf
);

    import sha_pkg::*;

    asm_state_t state;
    asm_state_t state_nx;

    logic [CNT_W-1:0]       cnt;
    logic [8*MAX_BYTES-1:0] word;
    logic                   drain;
    logic                   ready_q;
    logic                   hd_q;

    logic xfer;
    logic hd_rise;
    logic at_limit;
    logic store;
    logic set_drain;
    logic clr;

    assign xfer     = s_valid & ready_q;
    assign hd_rise  = hash_done & ~hd_q;
    assign at_limit = (cnt == CNT_W'(MAX_BYTES - 1));

    always_comb begin
        state_nx  = state;
        store     = 1'b0;
        set_drain = 1'b0;
        clr       = 1'b0;
        unique case (state)
            COLLECT: begin
                if (xfer) begin
                    store = 1'b1;
                    if (s_last) begin
                        state_nx = ISSUE;
                    end else if (at_limit) begin
                        // Full block without a terminator: issue what we
                        // have and swallow the rest of the message.
                        state_nx  = ISSUE;
                        set_drain = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nx = drain ? DRAIN : WAIT;
            end
            DRAIN: begin
                if (xfer && s_last) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (hd_rise) begin
                    state_nx = COLLECT;
                    clr      = 1'b1;
                end
            end
            default: begin
                state_nx = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            cnt     <= '0;
            word    <= '0;
            drain   <= 1'b0;
            ready_q <= 1'b0;
            hd_q    <= 1'b0;
        end else begin
            state <= state_nx;
            hd_q  <= hash_done;
            // Registered ready follows the state being entered, so it
            // stays low through reset and the first cycle after release.
            ready_q <= (state_nx == COLLECT) || (state_nx == DRAIN);
            if (clr) begin
                cnt   <= '0;
                word  <= '0;
                drain <= 1'b0;
            end else if (store) begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        word[8*(MAX_BYTES-i)-1 -: 8] <= s_data;
                    end
                end
                cnt <= cnt + CNT_W'(1);
                if (set_drain) begin
                    drain <= 1'b1;
                end
            end
        end
    end

    assign s_ready    = ready_q;
    assign msg_valid  = (state == ISSUE);
    assign ovf        = (state == ISSUE) & drain;
    assign byte_valid = cnt;
    assign msg_word   = word;

endmodule

// File: tb/tb_sha_msg_assembler.sv
// Self-checking bench for sha_msg_assembler: vector table, corner sequences
// and random messages against a queue-based packing model.
module tb_sha_msg_assembler;

    import sha_pkg::*;

    localparam int MB = MAX_BYTES;
    localparam int W  = 8 * MB;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          len;
        int          base;
        int          gmax;
        int          exp_bv;
        bit          exp_ov;
    } vec_t;

    typedef struct {
        int          bv;
        logic [W-1:0] word;
        bit          ov;
        int          xf;
    } cap_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       s_data = 8'h00;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             hash_done = 1'b0;
    logic             s_ready;
    logic             msg_valid;
    logic [CNT_W-1:0] byte_valid;
    logic [W-1:0]     msg_word;
    logic             ovf;

    int total = 0;
    int passed = 0;
    int exp_msgs = 0;
    int exp_ovfs = 0;

    cap_t caps[$];
    int   xcnt = 0;
    int   ovf_cnt = 0;

    sha_msg_assembler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .hash_done  (hash_done),
        .msg_valid  (msg_valid),
        .byte_valid (byte_valid),
        .msg_word   (msg_word),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (msg_valid) begin
            caps.push_back('{int'(byte_valid), msg_word, ovf, xcnt});
        end
        if (ovf) begin
            ovf_cnt++;
        end
        if (rst_n && s_valid && s_ready) begin
            xcnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input bq_t m);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < m.size() && k < MB; k++) begin
            w = w | (W'(m[k]) << (8 * (MB - 1 - k)));
        end
        return w;
    endfunction

    function automatic bq_t seq(input int len, input int base);
        bq_t q;
        for (int k = 0; k < len; k++) begin
            q.push_back(8'((base + k) % 256));
        end
        return q;
    endfunction

    task automatic send(input bq_t m, input int gmax, input bit poke,
                        output bit ok);
        int gap;
        int t;
        ok = 1'b1;
        for (int k = 0; k < m.size(); k++) begin
            gap = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
            s_valid = 1'b0;
            s_last  = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = m[k];
            s_last  = (k == m.size() - 1);
            if (poke && k == m.size() / 2) begin
                hash_done = 1'b1;
            end
            t = 0;
            while (!s_ready && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!s_ready) begin
                ok = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            hash_done = 1'b0;
        end
        s_valid   = 1'b0;
        s_last    = 1'b0;
        hash_done = 1'b0;
    endtask

    task automatic run_msg(input bq_t m, input int gmax, input bit poke,
                           input int exp_bv, input bit exp_ov);
        int xb;
        int ci;
        bit ok;
        cap_t c;
        xb = xcnt;
        ci = caps.size();
        exp_msgs++;
        if (exp_ov) begin
            exp_ovfs++;
        end
        send(m, gmax, poke, ok);
        chki("send_accepted", int'(ok), 1);
        if (m.size() <= MB) begin
            chk("latency_msg_valid", W'(msg_valid), W'(1));
            chk("ready_low_issue", W'(s_ready), W'(0));
        end
        for (int t = 0; t < 5 && caps.size() == ci; t++) begin
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chki("msg_count", caps.size() - ci, 1);
        if (caps.size() > ci) begin
            c = caps[ci];
            chki("byte_valid", c.bv, exp_bv);
            chk("msg_word", c.word, pack(m));
            chki("ovf_flag", int'(c.ov), int'(exp_ov));
            chki("xfers_at_issue", c.xf - xb,
                 (m.size() < MB) ? m.size() : MB);
        end
        chki("bytes_accepted", xcnt - xb, m.size());
        @(posedge clk);
        #1;
        chk("ready_low_wait", W'(s_ready), W'(0));
    endtask

    task automatic finish_hash();
        hash_done = 1'b1;
        @(posedge clk);
        #1;
        hash_done = 1'b0;
        chk("ready_after_done", W'(s_ready), W'(1));
    endtask

    vec_t tbl[6];
    bq_t  abc;
    bq_t  msg;

    initial begin
        int xb;
        int len;
        bit ov;

        tbl[0] = '{1,  8'h41, 0, 1,  1'b0};
        tbl[1] = '{55, 8'h00, 0, 55, 1'b0};
        tbl[2] = '{56, 8'h20, 0, 55, 1'b1};
        tbl[3] = '{60, 8'h10, 1, 55, 1'b1};
        tbl[4] = '{54, 8'h80, 2, 54, 1'b0};
        tbl[5] = '{2,  8'hF0, 3, 2,  1'b0};

        abc = '{8'h61, 8'h62, 8'h63};

        #3;
        chk("reset_ready", W'(s_ready), W'(0));
        chk("reset_strobes", W'({msg_valid, ovf}), W'(0));
        chk("reset_bv", W'(byte_valid), W'(0));
        chk("reset_word", msg_word, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", W'(s_ready), W'(1));

        run_msg(abc, 0, 1'b0, 3, 1'b0);
        chk("abc_top24", W'(caps[caps.size()-1].word[W-1 -: 24]),
            W'(24'h616263));

        // Bytes offered during WAIT must not be taken.
        xb = xcnt;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_last  = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chki("wait_no_xfer", xcnt - xb, 0);
        chk("wait_ready_low", W'(s_ready), W'(0));
        s_valid = 1'b0;
        s_last  = 1'b0;
        finish_hash();
        run_msg(abc, 0, 1'b0, 3, 1'b0);
        finish_hash();

        for (int i = 0; i < 6; i++) begin
            msg = seq(tbl[i].len, tbl[i].base);
            run_msg(msg, tbl[i].gmax, 1'b0, tbl[i].exp_bv, tbl[i].exp_ov);
            if (tbl[i].len == 55) begin
                chk("last_lane", W'(caps[caps.size()-1].word[7:0]),
                    W'(8'h36));
            end
            repeat (2) @(posedge clk);
            #1;
            chk("held_ready_low", W'(s_ready), W'(0));
            finish_hash();
        end

        msg = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
        run_msg(msg, 5, 1'b0, 5, 1'b0);
        chk("hello_top40", W'(caps[caps.size()-1].word[W-1 -: 40]),
            W'(40'h68656c6c6f));
        finish_hash();

        // hash_done held high across WAIT exit must not retrigger.
        run_msg(abc, 0, 1'b0, 3, 1'b0);
        hash_done = 1'b1;
        @(posedge clk);
        #1;
        chk("level_exit_ready", W'(s_ready), W'(1));
        run_msg(abc, 0, 1'b0, 3, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("level_no_retrig", W'(s_ready), W'(0));
        hash_done = 1'b0;
        @(posedge clk);
        #1;
        chk("fall_no_exit", W'(s_ready), W'(0));
        finish_hash();

        // Reset in the middle of a message.
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'hA0 + k);
            s_last  = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("partial_top16", W'(msg_word[W-1 -: 16]), W'(16'hA0A1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_word", msg_word, '0);
        chk("async_rst_outs", W'({s_ready, msg_valid, ovf, byte_valid}),
            W'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst2", W'(s_ready), W'(1));
        run_msg(abc, 0, 1'b0, 3, 1'b0);
        finish_hash();

        for (int r = 0; r < 25; r++) begin
            msg.delete();
            len = int'($urandom_range(1, 64));
            for (int k = 0; k < len; k++) begin
                msg.push_back(8'($urandom));
            end
            ov = (len > MB);
            run_msg(msg, 3, 1'($urandom_range(0, 3) == 0),
                    ov ? MB : len, ov);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            finish_hash();
        end

        chki("total_msgs", caps.size(), exp_msgs);
        chki("total_ovf", ovf_cnt, exp_ovfs);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
